// File: rtl/apb_master_bridge.sv
// Purpose: bridges a valid/ready command port to an APB master driving two slaves.
// Latency: 3 cycles from command acceptance to rsp_valid with zero wait states; +1 per PREADY-low ACCESS cycle.
// Backpressure: cmd_ready is high only in IDLE; a held command is taken as soon as the bridge returns to IDLE.
//
// Ports:
//   PCLK, PRESET              - clock, synchronous active-high reset
//   cmd_valid/cmd_ready       - command handshake; cmd_write, cmd_addr[8:0] (bit 8 = slave), cmd_wdata[7:0]
//   rsp_valid/rsp_rdata/rsp_err - one-cycle completion pulse with read data or timeout flag
//   PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA - registered APB request outputs
//   PRDATA1, PRDATA2, PREADY  - APB slave returns (PREADY shared by both slaves)
module apb_master_bridge #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [8:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       PSEL1,
  output logic       PSEL2,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA1,
  input  logic [7:0] PRDATA2,
  input  logic       PREADY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic [7:0] wait_inc;

  logic       psel1_nxt, psel2_nxt, penable_nxt, pwrite_nxt;
  logic [7:0] paddr_nxt, pwdata_nxt;
  logic       rsp_valid_nxt, rsp_err_nxt;
  logic [7:0] rsp_rdata_nxt;

  assign cmd_ready = (state == IDLE) && !PRESET;

  // Wait count after this stalled cycle; the abort fires on the edge where it reaches TIMEOUT.
  assign wait_inc = wait_cnt + 8'd1;

  always_comb begin
    state_nxt     = state;
    wait_nxt      = wait_cnt;
    psel1_nxt     = PSEL1;
    psel2_nxt     = PSEL2;
    penable_nxt   = PENABLE;
    pwrite_nxt    = PWRITE;
    paddr_nxt     = PADDR;
    pwdata_nxt    = PWDATA;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = 1'b0;
    rsp_rdata_nxt = 8'h00;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_nxt   = SETUP;
          wait_nxt    = 8'h00;
          psel1_nxt   = !cmd_addr[8];
          psel2_nxt   = cmd_addr[8];
          penable_nxt = 1'b0;
          pwrite_nxt  = cmd_write;
          paddr_nxt   = cmd_addr[7:0];
          pwdata_nxt  = cmd_write ? cmd_wdata : 8'h00;
        end
      end

      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
      end

      ACCESS: begin
        // PREADY wins over the timeout when both happen on the same edge.
        if (PREADY) begin
          state_nxt     = IDLE;
          psel1_nxt     = 1'b0;
          psel2_nxt     = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          // PSEL2 still holds the slave choice made at acceptance.
          rsp_rdata_nxt = PWRITE ? 8'h00 : (PSEL2 ? PRDATA2 : PRDATA1);
        end else if (wait_inc == 8'(TIMEOUT)) begin
          state_nxt     = IDLE;
          wait_nxt      = wait_inc;
          psel1_nxt     = 1'b0;
          psel2_nxt     = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
        end else begin
          wait_nxt = wait_inc;
        end
      end

      default: begin
        state_nxt   = IDLE;
        psel1_nxt   = 1'b0;
        psel2_nxt   = 1'b0;
        penable_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      wait_cnt  <= 8'h00;
      PSEL1     <= 1'b0;
      PSEL2     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= 8'h00;
      PWDATA    <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      PSEL1     <= psel1_nxt;
      PSEL2     <= psel2_nxt;
      PENABLE   <= penable_nxt;
      PWRITE    <= pwrite_nxt;
      PADDR     <= paddr_nxt;
      PWDATA    <= pwdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Purpose: directed self-checking bench for apb_master_bridge with a two-slave memory model.
// Latency: n/a (testbench).
// Backpressure: PREADY is driven per scenario to insert wait states or force a timeout.
module tb_apb_master_bridge;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [8:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA, PRDATA1, PRDATA2;
  logic       PREADY;

  // Slave model: byte memories, optionally overridden with fixed read data.
  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];
  logic       ovr;
  logic [7:0] ovr1, ovr2;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] s_addr, s_wdata;
    logic       s_write, s_sel1, s_sel2, s_pen;
    logic [7:0] rdata;
    logic       err, rdy_at_rsp;
    int         lat, acc;
    bit         stable, bus_ok, done;
  } obs_t;

  apb_master_bridge #(.TIMEOUT(15)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  assign PRDATA1 = ovr ? ovr1 : mem1[PADDR];
  assign PRDATA2 = ovr ? ovr2 : mem2[PADDR];

  always @(posedge PCLK) begin
    if (PENABLE && PREADY && PWRITE) begin
      if (PSEL1) mem1[PADDR] <= PWDATA;
      if (PSEL2) mem2[PADDR] <= PWDATA;
    end
  end

  // Drives one command and records what the bus and response did; c counts cycles after the accept edge.
  task automatic run_cmd(input logic w, input logic [8:0] a, input logic [7:0] d,
                         input int stall, output obs_t o);
    int n;
    o.s_addr = 0; o.s_wdata = 0; o.s_write = 0; o.s_sel1 = 0; o.s_sel2 = 0; o.s_pen = 0;
    o.rdata = 0; o.err = 0; o.rdy_at_rsp = 0; o.lat = 0; o.acc = 0;
    o.stable = 1; o.bus_ok = 1; o.done = 0;
    @(negedge PCLK);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    PREADY = 1'b1;  // high outside ACCESS; must be ignored there
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge PCLK); n++; end
    @(negedge PCLK);
    cmd_valid = 0;
    for (int c = 1; c <= 200 && !o.done; c++) begin
      if (c == 1) begin
        o.s_addr = PADDR; o.s_wdata = PWDATA; o.s_write = PWRITE;
        o.s_sel1 = PSEL1; o.s_sel2 = PSEL2; o.s_pen = PENABLE;
      end
      if (PSEL1 && PSEL2) o.bus_ok = 0;
      if (PENABLE && !(PSEL1 || PSEL2)) o.bus_ok = 0;
      if (PENABLE) begin
        o.acc++;
        if (PADDR !== o.s_addr || PWRITE !== o.s_write || PWDATA !== o.s_wdata ||
            PSEL1 !== o.s_sel1 || PSEL2 !== o.s_sel2) o.stable = 0;
        PREADY = (o.acc > stall);
      end
      if (rsp_valid) begin
        o.done = 1; o.lat = c; o.rdata = rsp_rdata; o.err = rsp_err; o.rdy_at_rsp = cmd_ready;
      end else begin
        @(negedge PCLK);
      end
    end
  endtask

  task automatic test_reset();
    PRESET = 1; cmd_valid = 1; cmd_write = 1; cmd_addr = 9'h0AA; cmd_wdata = 8'h55; PREADY = 1;
    repeat (2) @(negedge PCLK);
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    tests++; if ({PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b0) begin fails++; $display("FAIL reset_ctrl: got %b want 0000", {PSEL1, PSEL2, PENABLE, PWRITE}); end
    tests++; if ({PADDR, PWDATA} !== 16'h0) begin fails++; $display("FAIL reset_addr_data: got %h want 0000", {PADDR, PWDATA}); end
    tests++; if ({rsp_valid, rsp_err, rsp_rdata} !== 10'h0) begin fails++; $display("FAIL reset_rsp: got %h want 000", {rsp_valid, rsp_err, rsp_rdata}); end
    PRESET = 0; cmd_valid = 0;
    #1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL idle_cmd_ready: got %b want 1", cmd_ready); end
    @(negedge PCLK);
    tests++; if ({PSEL1, PSEL2} !== 2'b00) begin fails++; $display("FAIL no_accept_in_reset: got %b want 00", {PSEL1, PSEL2}); end
  endtask

  task automatic test_write_read_s1();
    obs_t o;
    run_cmd(1'b1, 9'h012, 8'hA5, 0, o);
    tests++; if (o.s_addr !== 8'h12) begin fails++; $display("FAIL wr_paddr: got %h want 12", o.s_addr); end
    tests++; if ({o.s_write, o.s_wdata} !== 9'h1A5) begin fails++; $display("FAIL wr_pwrite_pwdata: got %h want 1a5", {o.s_write, o.s_wdata}); end
    tests++; if ({o.s_sel1, o.s_sel2, o.s_pen} !== 3'b100) begin fails++; $display("FAIL wr_setup_sel: got %b want 100", {o.s_sel1, o.s_sel2, o.s_pen}); end
    tests++; if (o.lat !== 3) begin fails++; $display("FAIL wr_latency: got %0d want 3", o.lat); end
    tests++; if ({o.err, o.rdata} !== 9'h000) begin fails++; $display("FAIL wr_rsp: got %h want 000", {o.err, o.rdata}); end
    run_cmd(1'b0, 9'h012, 8'h5A, 0, o);
    tests++; if ({o.s_write, o.s_wdata} !== 9'h000) begin fails++; $display("FAIL rd_pwrite_pwdata: got %h want 000", {o.s_write, o.s_wdata}); end
    tests++; if (o.lat !== 3 || o.acc !== 1) begin fails++; $display("FAIL rd_latency: got lat %0d acc %0d want 3 1", o.lat, o.acc); end
    tests++; if ({o.err, o.rdata} !== 9'h0A5) begin fails++; $display("FAIL rd_rsp: got %h want 0a5", {o.err, o.rdata}); end
    tests++; if (o.rdy_at_rsp !== 1'b1) begin fails++; $display("FAIL rd_ready_at_rsp: got %b want 1", o.rdy_at_rsp); end
    @(negedge PCLK);
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rsp_pulse_width: got %b want 0", rsp_valid); end
  endtask

  task automatic test_slave2();
    obs_t o;
    ovr = 1; ovr1 = 8'hFF; ovr2 = 8'h3C;
    run_cmd(1'b0, 9'h180, 8'h00, 0, o);
    tests++; if ({o.s_sel1, o.s_sel2} !== 2'b01) begin fails++; $display("FAIL s2_sel: got %b want 01", {o.s_sel1, o.s_sel2}); end
    tests++; if (o.s_addr !== 8'h80) begin fails++; $display("FAIL s2_paddr: got %h want 80", o.s_addr); end
    tests++; if ({o.err, o.rdata} !== 9'h03C) begin fails++; $display("FAIL s2_rdata: got %h want 03c", {o.err, o.rdata}); end
    tests++; if (!o.bus_ok || !o.stable) begin fails++; $display("FAIL s2_bus: got ok %0d stable %0d want 1 1", o.bus_ok, o.stable); end
    ovr = 0;
  endtask

  task automatic test_wait_states();
    obs_t o;
    run_cmd(1'b1, 9'h033, 8'hC3, 4, o);
    tests++; if (o.acc !== 5 || o.lat !== 7) begin fails++; $display("FAIL wait_timing: got acc %0d lat %0d want 5 7", o.acc, o.lat); end
    tests++; if (!o.stable || !o.bus_ok) begin fails++; $display("FAIL wait_stable: got stable %0d ok %0d want 1 1", o.stable, o.bus_ok); end
    tests++; if ({o.done, o.err} !== 2'b10) begin fails++; $display("FAIL wait_rsp: got done/err %b want 10", {o.done, o.err}); end
  endtask

  task automatic test_timeout();
    obs_t o;
    ovr = 1; ovr1 = 8'h11; ovr2 = 8'hEE;
    run_cmd(1'b0, 9'h155, 8'h00, 1000, o);
    tests++; if (!o.done) begin fails++; $display("FAIL to_no_rsp: got no rsp_valid within budget, want one"); end
    tests++; if ({o.err, o.rdata} !== 9'h100) begin fails++; $display("FAIL to_rsp: got %h want 100", {o.err, o.rdata}); end
    tests++; if (o.acc !== 15 || o.lat !== 17) begin fails++; $display("FAIL to_timing: got acc %0d lat %0d want 15 17", o.acc, o.lat); end
    tests++; if ({PSEL1, PSEL2, PENABLE, cmd_ready} !== 4'b0001) begin fails++; $display("FAIL to_idle: got %b want 0001", {PSEL1, PSEL2, PENABLE, cmd_ready}); end
    ovr = 0; PREADY = 1;
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    int n;
    @(negedge PCLK);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 9'h012; cmd_wdata = 8'h00; PREADY = 0;
    n = 0;
    while (!PENABLE && n < 20) begin @(negedge PCLK); n++; end
    tests++; if (PENABLE !== 1'b1) begin fails++; $display("FAIL mid_reach_access: got %b want 1", PENABLE); end
    cmd_valid = 0; PRESET = 1; PREADY = 1;
    @(negedge PCLK);
    tests++; if ({PSEL1, PSEL2, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready} !== 7'b0) begin fails++; $display("FAIL mid_ctrl_clear: got %b want 0000000", {PSEL1, PSEL2, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready}); end
    tests++; if ({PADDR, PWDATA, rsp_rdata} !== 24'h0) begin fails++; $display("FAIL mid_data_clear: got %h want 000000", {PADDR, PWDATA, rsp_rdata}); end
    PRESET = 0;
    @(negedge PCLK);
    tests++; if ({rsp_valid, PSEL1, PSEL2} !== 3'b000) begin fails++; $display("FAIL mid_no_rsp: got %b want 000", {rsp_valid, PSEL1, PSEL2}); end
    run_cmd(1'b0, 9'h012, 8'h00, 0, o);
    tests++; if (o.lat !== 3 || {o.err, o.rdata} !== 9'h0A5) begin fails++; $display("FAIL mid_next_cmd: got lat %0d rsp %h want 3 0a5", o.lat, {o.err, o.rdata}); end
  endtask

  task automatic test_back_to_back();
    logic       cw [3];
    logic [8:0] ca [3];
    logic [7:0] cd [3];
    logic [7:0] exp_rd [3];
    logic [7:0] got_rd [3];
    int acc_t [3];
    int rsp_t [3];
    int k, r, bus_bad, seq_bad;
    bit pending, prev_pen, prev_setup;
    cw = '{1'b1, 1'b0, 1'b0};
    ca = '{9'h140, 9'h140, 9'h012};
    cd = '{8'h77, 8'h00, 8'h00};
    exp_rd = '{8'h00, 8'h77, 8'hA5};
    for (int i = 0; i < 3; i++) begin acc_t[i] = -1; rsp_t[i] = -1; got_rd[i] = 8'h00; end
    k = 0; r = 0; bus_bad = 0; seq_bad = 0; pending = 0; prev_pen = 0; prev_setup = 0;
    @(negedge PCLK);
    PREADY = 1; cmd_valid = 1; cmd_write = cw[0]; cmd_addr = ca[0]; cmd_wdata = cd[0];
    for (int t = 0; t < 16; t++) begin
      if (PSEL1 && PSEL2) bus_bad++;
      if (PENABLE && !(PSEL1 || PSEL2)) bus_bad++;
      if (PENABLE && !prev_pen && !prev_setup) seq_bad++;
      if (rsp_valid && r < 3) begin rsp_t[r] = t; got_rd[r] = rsp_rdata; r++; end
      if (cmd_valid && cmd_ready && k < 3) begin acc_t[k] = t; k++; pending = 1; end
      prev_pen = PENABLE;
      prev_setup = (PSEL1 || PSEL2) && !PENABLE;
      @(negedge PCLK);
      if (pending) begin
        pending = 0;
        if (k < 3) begin cmd_write = cw[k]; cmd_addr = ca[k]; cmd_wdata = cd[k]; end
        else cmd_valid = 0;
      end
    end
    cmd_valid = 0;
    tests++; if (r !== 3 || k !== 3) begin fails++; $display("FAIL b2b_count: got rsp %0d acc %0d want 3 3", r, k); end
    tests++; if (rsp_t[0] - acc_t[0] !== 3) begin fails++; $display("FAIL b2b_first_latency: got %0d want 3", rsp_t[0] - acc_t[0]); end
    tests++; if (acc_t[1] !== rsp_t[0] || acc_t[2] !== rsp_t[1]) begin fails++; $display("FAIL b2b_accept_gap: got acc %0d %0d rsp %0d %0d want equal pairs", acc_t[1], acc_t[2], rsp_t[0], rsp_t[1]); end
    tests++; if (got_rd[0] !== exp_rd[0] || got_rd[1] !== exp_rd[1] || got_rd[2] !== exp_rd[2]) begin fails++; $display("FAIL b2b_rdata: got %h %h %h want %h %h %h", got_rd[0], got_rd[1], got_rd[2], exp_rd[0], exp_rd[1], exp_rd[2]); end
    tests++; if (bus_bad !== 0 || seq_bad !== 0) begin fails++; $display("FAIL b2b_protocol: got bus %0d seq %0d violations want 0 0", bus_bad, seq_bad); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem1[i] = 8'h00; mem2[i] = 8'h00; end
    ovr = 0; ovr1 = 8'h00; ovr2 = 8'h00;
    PRESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 9'h000; cmd_wdata = 8'h00; PREADY = 0;
    test_reset();
    test_write_read_s1();
    test_slave2();
    test_wait_states();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
